// File: rtl/calc_rpn_pkg.sv
// Shared definitions for the RPN calculator core:
// opcodes, FSM encoding and the unary-op predicate.
package calc_rpn_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    GRAVA   = 2'd2
  } estado_e;

  function automatic logic is_unary(
    input logic [2:0] op
  );
    return (op == OP_NOT) ||
           (op == OP_SHL) ||
           (op == OP_SHR);
  endfunction

endpackage

// File: rtl/ula_nbits.sv
// Combinational ALU: binary ops use a (below) and b (top),
// unary ops act on b alone.
module ula_nbits
  import calc_rpn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel_op,
  output logic [WIDTH-1:0] resultado,
  output logic             carry
);

  logic [WIDTH:0] soma;
  logic [WIDTH:0] dif;

  assign soma = {1'b0, a} + {1'b0, b};
  // MSB of the extended difference is the borrow (a < b)
  assign dif  = {1'b0, a} - {1'b0, b};

  always_comb begin
    resultado = '0;
    carry     = 1'b0;
    unique case (sel_op)
      OP_ADD: {carry, resultado} = soma;
      OP_SUB: {carry, resultado} = dif;
      OP_AND: resultado = a & b;
      OP_OR:  resultado = a | b;
      OP_XOR: resultado = a ^ b;
      OP_NOT: resultado = ~b;
      OP_SHL: {carry, resultado} = {b, 1'b0};
      OP_SHR: {resultado, carry} = {1'b0, b};
    endcase
  end

endmodule

// File: rtl/calculadora_rpn_pilha.sv
// RPN calculator core: shift-array operand stack, 3-state
// execute FSM, carry/zero flags and sticky error reporting.
module calculadora_rpn_pilha
  import calc_rpn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enter_pulso,
  input  logic                       executar_pulso,
  input  logic                       limpa_pulso,
  input  logic [WIDTH-1:0]           dados,
  input  logic [2:0]                 sel_op,
  output logic [WIDTH-1:0]           topo,
  output logic [$clog2(DEPTH+1)-1:0] nivel,
  output logic                       carry,
  output logic                       zero,
  output logic                       ocupado,
  output logic                       erro_cheia,
  output logic                       erro_vazia
);

  localparam int NW = $clog2(DEPTH+1);
  localparam logic [NW-1:0] CHEIO = NW'(DEPTH);

  estado_e estado, prox;

  logic [WIDTH-1:0] pilha [DEPTH];
  logic [NW-1:0]    nivel_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] res_q;
  logic             c_q;
  logic [WIDTH-1:0] ula_res;
  logic             ula_c;

  logic ociosa;
  logic falta_op;
  logic faz_limpa;
  logic faz_exec;
  logic exec_ok;
  logic faz_enter;

  assign ociosa   = (estado == OCIOSO);
  assign falta_op = is_unary(sel_op) ?
                    (nivel_q == '0) :
                    (nivel_q < NW'(2));

  // priority: limpa > executar > enter
  assign faz_limpa = ociosa & limpa_pulso;
  assign faz_exec  = ociosa & ~limpa_pulso &
                     executar_pulso;
  assign exec_ok   = faz_exec & ~falta_op;
  assign faz_enter = ociosa & ~limpa_pulso &
                     ~executar_pulso & enter_pulso;

  ula_nbits #(.WIDTH(WIDTH)) u_ula (
    .a         (pilha[1]),
    .b         (pilha[0]),
    .sel_op    (op_q),
    .resultado (ula_res),
    .carry     (ula_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) estado <= OCIOSO;
    else          estado <= prox;
  end

  always_comb begin
    prox = estado;
    unique case (estado)
      OCIOSO:  if (exec_ok) prox = CALCULA;
      CALCULA: prox = GRAVA;
      GRAVA:   prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado = (estado != OCIOSO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        pilha[i] <= '0;
      nivel_q    <= '0;
      op_q       <= OP_ADD;
      res_q      <= '0;
      c_q        <= 1'b0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      erro_cheia <= 1'b0;
      erro_vazia <= 1'b0;
    end else if (faz_limpa) begin
      for (int i = 0; i < DEPTH; i++)
        pilha[i] <= '0;
      nivel_q    <= '0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      erro_cheia <= 1'b0;
      erro_vazia <= 1'b0;
    end else if (faz_exec) begin
      if (falta_op) erro_vazia <= 1'b1;
      else          op_q       <= sel_op;
    end else if (faz_enter) begin
      if (nivel_q == CHEIO) begin
        erro_cheia <= 1'b1;
      end else begin
        for (int i = DEPTH-1; i > 0; i--)
          pilha[i] <= pilha[i-1];
        pilha[0] <= dados;
        nivel_q  <= nivel_q + NW'(1);
      end
    end else if (estado == CALCULA) begin
      res_q <= ula_res;
      c_q   <= ula_c;
    end else if (estado == GRAVA) begin
      carry <= c_q;
      zero  <= (res_q == '0);
      pilha[0] <= res_q;
      if (!is_unary(op_q)) begin
        // pop two, push one: entries below shift up
        for (int i = 1; i < DEPTH-1; i++)
          pilha[i] <= pilha[i+1];
        pilha[DEPTH-1] <= '0;
        nivel_q <= nivel_q - NW'(1);
      end
    end
  end

  assign topo  = pilha[0];
  assign nivel = nivel_q;

endmodule
